fft_sram_arbiter: RTL and testbench

Arbitrates single-port 512x16 on-chip sample SRAM between three requesters:
- 0 = Avalon slave loader (host writes samples)
- 1 = FFT butterfly engine (read/modify/write)
- 2 = Avalon master drain (readout to system memory)

Round-robin by default. A requester may lock the port for short bursts, with starvation protection. Sits between the three requesters and the SRAM f_* interface, and owns all SRAM command timing and read-data return.

---
 rtl/fft_pkg.sv | 15 +
 rtl/rr_lock_arbiter.sv | 55 +++++
 rtl/fft_sram_arbiter.sv | 92 +++++++++
 tb/tb_fft_sram_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared sample-SRAM widths, types and requester ids
package fft_pkg;
   localparam int ADDR_W     = 9;
   localparam int DATA_W     = 16;
   localparam int SRAM_DEPTH = 512;

   typedef logic [ADDR_W-1:0] sram_addr_t;
   typedef logic [DATA_W-1:0] sram_data_t;

   typedef enum logic [1:0] {
      REQ_LOAD  = 2'd0,
      REQ_FFT   = 2'd1,
      REQ_DRAIN = 2'd2
   } req_id_t;
endpackage

// File: rtl/rr_lock_arbiter.sv
// rtl/rr_lock_arbiter.sv - round-robin grant with bounded lock bursts
// Holds last_owner and lock_cnt; grant is combinational and forced to zero during reset.
module rr_lock_arbiter #(
   parameter int NREQ     = 3,
   parameter int MAX_LOCK = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NREQ-1:0] req,
   input  logic [NREQ-1:0] lock,
   output logic [NREQ-1:0] gnt
);
   import fft_pkg::*;

   localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CNT_W = (MAX_LOCK > 2) ? $clog2(MAX_LOCK) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LOCK - 1);

   logic [IDX_W-1:0] last_owner_d, last_owner_q;
   logic [CNT_W-1:0] lock_cnt_d, lock_cnt_q;
   logic [IDX_W-1:0] cand;

   always_comb begin
      gnt          = '0;
      last_owner_d = last_owner_q;
      lock_cnt_d   = '0;
      cand         = '0;
      if (!rst) begin
         if (req[last_owner_q] && lock[last_owner_q] && (lock_cnt_q < CNT_MAX)) begin
            gnt[last_owner_q] = 1'b1;
            lock_cnt_d        = lock_cnt_q + CNT_W'(1);
         end else begin
            // Walk the ring backwards so the nearest requester after last_owner is written last.
            for (int k = NREQ; k >= 1; k--) begin
               cand = IDX_W'((int'(last_owner_q) + k) % NREQ);
               if (req[cand]) begin
                  gnt          = '0;
                  gnt[cand]    = 1'b1;
                  last_owner_d = cand;
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_owner_q <= IDX_W'(NREQ - 1);
         lock_cnt_q   <= '0;
      end else begin
         last_owner_q <= last_owner_d;
         lock_cnt_q   <= lock_cnt_d;
      end
   end
endmodule

// File: rtl/fft_sram_arbiter.sv
// rtl/fft_sram_arbiter.sv - three-way single-port sample SRAM arbiter
// Registers the granted command toward the SRAM and returns read data through a tag pipeline.
module fft_sram_arbiter #(
   parameter int NREQ     = 3,
   parameter int ADDR_W   = fft_pkg::ADDR_W,
   parameter int DATA_W   = fft_pkg::DATA_W,
   parameter int RD_LAT   = 1,
   parameter int MAX_LOCK = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NREQ-1:0]        req,
   input  logic [NREQ-1:0]        we,
   input  logic [NREQ-1:0]        lock,
   input  logic [NREQ*ADDR_W-1:0] addr,
   input  logic [NREQ*DATA_W-1:0] wdata,
   output logic [NREQ-1:0]        gnt,
   output logic [NREQ-1:0]        rvalid,
   output logic [DATA_W-1:0]      rdata,
   output logic                   f_wren,
   output logic                   f_rden,
   output logic [ADDR_W-1:0]      f_address,
   output logic [DATA_W-1:0]      f_data,
   input  logic [DATA_W-1:0]      f_q
);
   import fft_pkg::*;

   logic              wren_d, wren_q, rden_d, rden_q;
   logic [ADDR_W-1:0] addr_d, addr_q;
   logic [DATA_W-1:0] data_d, data_q;
   logic [NREQ-1:0]   tag_d [RD_LAT+1];
   logic [NREQ-1:0]   tag_q [RD_LAT+1];
   logic [NREQ-1:0]   rvalid_d, rvalid_q;
   logic [DATA_W-1:0] rdata_d, rdata_q;

   rr_lock_arbiter #(.NREQ(NREQ), .MAX_LOCK(MAX_LOCK)) u_arb (
      .clk  (clk),
      .rst  (rst),
      .req  (req),
      .lock (lock),
      .gnt  (gnt)
   );

   always_comb begin
      wren_d = 1'b0;
      rden_d = 1'b0;
      addr_d = addr_q;
      data_d = data_q;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt[i]) begin
            wren_d = we[i];
            rden_d = ~we[i];
            addr_d = addr[i*ADDR_W +: ADDR_W];
            data_d = wdata[i*DATA_W +: DATA_W];
         end
      end
      // Tag is the one-hot owner of a read; writes enter as zero and never raise rvalid.
      for (int s = 0; s <= RD_LAT; s++) tag_d[s] = '0;
      tag_d[0] = gnt & ~we;
      for (int s = 1; s <= RD_LAT; s++) tag_d[s] = tag_q[s-1];
      rvalid_d = tag_q[RD_LAT];
      rdata_d  = (|tag_q[RD_LAT]) ? f_q : rdata_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wren_q   <= 1'b0;
         rden_q   <= 1'b0;
         addr_q   <= '0;
         data_q   <= '0;
         rvalid_q <= '0;
         rdata_q  <= '0;
         for (int s = 0; s <= RD_LAT; s++) tag_q[s] <= '0;
      end else begin
         wren_q   <= wren_d;
         rden_q   <= rden_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
         rvalid_q <= rvalid_d;
         rdata_q  <= rdata_d;
         for (int s = 0; s <= RD_LAT; s++) tag_q[s] <= tag_d[s];
      end
   end

   // Gating with rst keeps the command from the last pre-reset grant off the SRAM.
   assign f_wren    = wren_q & ~rst;
   assign f_rden    = rden_q & ~rst;
   assign f_address = addr_q;
   assign f_data    = data_q;
   assign rvalid    = rvalid_q;
   assign rdata     = rdata_q;
endmodule

// File: tb/tb_fft_sram_arbiter.sv
// tb/tb_fft_sram_arbiter.sv - directed and randomized bench for fft_sram_arbiter
module tb_fft_sram_arbiter;
   localparam int NREQ = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [2:0]  req, we, lock;
   logic [26:0] addr;
   logic [47:0] wdata;

   logic [2:0]  gnt, rvalid;
   logic [15:0] rdata, f_data, f_q;
   logic        f_wren, f_rden;
   logic [8:0]  f_address;

   logic [2:0]  gnt_s, rvalid_s;
   logic [15:0] rdata_s, f_data_s, f_q_s;
   logic        f_wren_s, f_rden_s;
   logic [8:0]  f_address_s;
   assign f_q_s = 16'h0000;

   fft_sram_arbiter #(.MAX_LOCK(8)) dut (
      .clk(clk), .rst(rst), .req(req), .we(we), .lock(lock), .addr(addr), .wdata(wdata),
      .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .f_wren(f_wren), .f_rden(f_rden),
      .f_address(f_address), .f_data(f_data), .f_q(f_q)
   );

   fft_sram_arbiter #(.MAX_LOCK(3)) dut_s (
      .clk(clk), .rst(rst), .req(req), .we(we), .lock(lock), .addr(addr), .wdata(wdata),
      .gnt(gnt_s), .rvalid(rvalid_s), .rdata(rdata_s), .f_wren(f_wren_s), .f_rden(f_rden_s),
      .f_address(f_address_s), .f_data(f_data_s), .f_q(f_q_s)
   );

   function automatic logic [15:0] init_word(input int a);
      init_word = 16'((a * 16'h1357) ^ 16'hA5A5);
   endfunction

   // SRAM with one cycle of read latency; unwritten words return a fixed address pattern.
   logic [15:0] sram [512];
   bit          written [512];
   always @(posedge clk) begin
      if (f_wren) begin
         sram[f_address]    <= f_data;
         written[f_address] <= 1'b1;
      end
      if (f_rden) f_q <= written[f_address] ? sram[f_address] : init_word(int'(f_address));
   end

   int n_cmp = 0, n_fail = 0, cyc = 0;

   int          lo [2];
   int          lc [2];
   int          maxl [2];
   logic [15:0] mmem [512];
   logic [2:0]  exp_rv [2048];
   logic [15:0] exp_rd [2048];
   bit          pend_v, pend_we;
   int          pend_own;
   logic [8:0]  pend_a, hold_a;
   logic [15:0] pend_d;
   int          g_last;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [2:0] oh(input int i);
      oh = (i < 0) ? 3'b000 : 3'(1 << i);
   endfunction

   function automatic int pick(input int m, output bit locked);
      int o, c;
      locked = 1'b0;
      o = lo[m];
      if (req[o[1:0]] && lock[o[1:0]] && lc[m] < maxl[m] - 1) begin
         locked = 1'b1;
         return o;
      end
      for (int k = 1; k <= NREQ; k++) begin
         c = (o + k) % NREQ;
         if (req[c[1:0]]) return c;
      end
      return -1;
   endfunction

   task automatic model_reset();
      for (int m = 0; m < 2; m++) begin
         lo[m] = NREQ - 1;
         lc[m] = 0;
      end
      pend_v = 1'b0;
      hold_a = '0;
      g_last = -1;
   endtask

   task automatic check_cycle();
      int g [2];
      bit lk [2];
      for (int m = 0; m < 2; m++) begin
         g[m]  = -1;
         lk[m] = 1'b0;
         if (!rst) g[m] = pick(m, lk[m]);
      end
      chk("gnt", gnt, oh(g[0]));
      chk("gnt_s", gnt_s, oh(g[1]));
      chk("f_wren", f_wren, !rst && pend_v && pend_we);
      chk("f_rden", f_rden, !rst && pend_v && !pend_we);
      chk("f_address", f_address, hold_a);
      if (!rst && pend_v && pend_we) chk("f_data", f_data, pend_d);
      chk("rvalid", rvalid, exp_rv[cyc]);
      if (exp_rv[cyc] != 3'b000) chk("rdata", rdata, exp_rd[cyc]);

      if (rst) begin
         model_reset();
         for (int k = cyc + 1; k < 2048; k++) exp_rv[k] = 3'b000;
      end else begin
         if (pend_v) begin
            if (pend_we) mmem[pend_a] = pend_d;
            else begin
               exp_rv[cyc+2] = oh(pend_own);
               exp_rd[cyc+2] = mmem[pend_a];
            end
         end
         pend_v = (g[0] >= 0);
         if (pend_v) begin
            pend_own = g[0];
            pend_we  = we[g[0]];
            pend_a   = addr[g[0]*9 +: 9];
            pend_d   = wdata[g[0]*16 +: 16];
            hold_a   = pend_a;
         end
         for (int m = 0; m < 2; m++) begin
            if (g[m] < 0) lc[m] = 0;
            else if (lk[m]) lc[m] = lc[m] + 1;
            else begin
               lc[m] = 0;
               lo[m] = g[m];
            end
         end
         g_last = g[0];
      end
      cyc++;
   endtask

   task automatic finish_cycle();
      check_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic step();
      @(negedge clk);
      finish_cycle();
   endtask

   task automatic step_exp(input string tag, input logic [2:0] e8, input logic [2:0] es);
      @(negedge clk);
      chk({tag, "_gnt"}, gnt, e8);
      chk({tag, "_gnt_s"}, gnt_s, es);
      finish_cycle();
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      req = 3'b000;
      lock = 3'b000;
      step();
      rst = 1'b0;
   endtask

   function automatic logic [8:0] rand_addr();
      if ($urandom_range(0, 3) == 0) return 9'($urandom_range(0, 511));
      return 9'($urandom_range(0, 7)) ^ (($urandom_range(0, 1) == 1) ? 9'h1F8 : 9'h000);
   endfunction

   bit pending [3];
   logic [2:0] e4_8 [6];
   logic [2:0] e4_s [6];
   logic [2:0] e5_8 [6];
   logic [2:0] e5_s [6];

   initial begin
      maxl[0] = 8;
      maxl[1] = 3;
      for (int i = 0; i < 512; i++) mmem[i] = init_word(i);
      for (int k = 0; k < 2048; k++) begin
         exp_rv[k] = 3'b000;
         exp_rd[k] = 16'h0000;
      end
      model_reset();
      e4_8 = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b100, 3'b001};
      e4_s = '{3'b010, 3'b010, 3'b010, 3'b100, 3'b001, 3'b010};
      e5_8 = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b010, 3'b010};
      e5_s = '{3'b010, 3'b010, 3'b010, 3'b100, 3'b001, 3'b010};

      // Reset held with all requesters active
      rst   = 1'b1;
      req   = 3'b111;
      we    = 3'b000;
      lock  = 3'b000;
      addr  = {9'h0A2, 9'h051, 9'h1FF};
      wdata = {16'h3333, 16'h2222, 16'h1111};
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst_gnt", gnt, 3'b000);
         chk("rst_rvalid", rvalid, 3'b000);
         chk("rst_f_rden", f_rden, 1'b0);
         chk("rst_f_address", f_address, 9'h000);
         finish_cycle();
      end
      rst = 1'b0;

      // Fairness: all three reading, strict rotation
      for (int r = 0; r < 3; r++) begin
         step_exp("rot", 3'b001, 3'b001);
         step_exp("rot", 3'b010, 3'b010);
         step_exp("rot", 3'b100, 3'b100);
      end
      req = 3'b000;
      for (int i = 0; i < 3; i++) step();

      // Write then read of the same word on consecutive grants
      pulse_reset();
      req = 3'b001;
      we  = 3'b001;
      addr[0 +: 9]   = 9'h005;
      wdata[0 +: 16] = 16'hABCD;
      step_exp("raw_wr", 3'b001, 3'b001);
      req = 3'b010;
      we  = 3'b000;
      addr[9 +: 9] = 9'h005;
      @(negedge clk);
      chk("raw_gnt", gnt, 3'b010);
      chk("raw_f_wren", f_wren, 1'b1);
      chk("raw_f_address", f_address, 9'h005);
      chk("raw_f_data", f_data, 16'hABCD);
      finish_cycle();
      req = 3'b000;
      step();
      step();
      @(negedge clk);
      chk("raw_rvalid", rvalid, 3'b010);
      chk("raw_rdata", rdata, 16'hABCD);
      finish_cycle();

      // Lock burst of four cycles
      pulse_reset();
      req = 3'b111;
      step_exp("lock4", 3'b001, 3'b001);
      lock = 3'b010;
      for (int i = 0; i < 6; i++) begin
         if (i == 4) lock = 3'b000;
         step_exp("lock4", e4_8[i], e4_s[i]);
      end

      // Lock held six cycles: starvation guard on the short-limit instance
      pulse_reset();
      req = 3'b111;
      step_exp("lock6", 3'b001, 3'b001);
      lock = 3'b010;
      for (int i = 0; i < 6; i++) step_exp("lock6", e5_8[i], e5_s[i]);
      lock = 3'b000;
      step_exp("lock6_end", 3'b100, 3'b100);
      req = 3'b000;
      for (int i = 0; i < 3; i++) step();

      // Reset the cycle after a read grant to the top word
      pulse_reset();
      req = 3'b001;
      we  = 3'b000;
      addr[0 +: 9] = 9'h1FF;
      step_exp("rstrd", 3'b001, 3'b001);
      rst = 1'b1;
      req = 3'b000;
      @(negedge clk);
      chk("rstrd_f_rden_rst", f_rden, 1'b0);
      finish_cycle();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("rstrd_rvalid", rvalid, 3'b000);
         chk("rstrd_f_rden", f_rden, 1'b0);
         finish_cycle();
      end
      req = 3'b111;
      step_exp("rstrd_next", 3'b001, 3'b001);
      req = 3'b000;
      for (int i = 0; i < 3; i++) step();

      // Randomized traffic: requesters hold until granted, locks and occasional resets
      for (int i = 0; i < 3; i++) pending[i] = 1'b0;
      for (int t = 0; t < 400; t++) begin
         rst = ($urandom_range(0, 149) == 0);
         for (int i = 0; i < 3; i++) begin
            if (!pending[i] && $urandom_range(0, 2) != 0) begin
               pending[i]           = 1'b1;
               we[i]                = 1'($urandom_range(0, 1));
               addr[i*9 +: 9]       = rand_addr();
               wdata[i*16 +: 16]    = 16'($urandom);
            end
            lock[i] = ($urandom_range(0, 3) != 0);
         end
         req = {pending[2], pending[1], pending[0]};
         step();
         if (g_last >= 0) pending[g_last] = 1'b0;
      end
      rst  = 1'b0;
      req  = 3'b000;
      lock = 3'b000;
      for (int i = 0; i < 4; i++) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
